// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD port widths, FSM encoding and a one-hot decode helper.
package lcd_pkg;
  localparam int LCD_LOC_W = 5;
  localparam int LCD_DATA_W = 8;
  localparam int LCD_LINE2_BASE = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;
  function automatic logic [2:0] oh_idx(input logic [7:0] oh);
    oh_idx = '0;
    for (int k = 0; k < 8; k++) if (oh[k]) oh_idx = 3'(k);
  endfunction
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: one-hot pick of the first set req at or after ptr, wrapping.
module rr_priority_select #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  sel,
  output logic          valid
);
  // Scan farthest-first so the candidate nearest ptr overwrites the others.
  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        sel = '0;
        sel[(int'(ptr) + k) % N] = 1'b1;
      end
  end
  assign valid = |req;
endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin sharing of the LcdController character-write port
// with a programmable idle gap after every write strobe.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WRITE_GAP = 16,
  parameter int GAP_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [LCD_LOC_W*NUM_REQ-1:0]    reqLocation,
  input  logic [LCD_DATA_W*NUM_REQ-1:0]   reqData,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            lcdWriteEnable,
  output logic [LCD_LOC_W-1:0]            lcdLocation,
  output logic [LCD_DATA_W-1:0]           lcdData,
  output logic                            busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WRITE_GAP == 0 ? 0 : WRITE_GAP - 1);
  logic [1:0] state_q, state_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d, sel_idx;
  logic [NUM_REQ-1:0] grant_q, grant_d, sel_oh;
  logic we_q, we_d, sel_valid;
  logic [LCD_LOC_W-1:0] loc_q, loc_d, loc_sel;
  logic [LCD_DATA_W-1:0] data_q, data_d, data_sel;
  rr_priority_select #(.N(NUM_REQ)) u_sel (
    .req  (req),
    .ptr  (ptr_q),
    .sel  (sel_oh),
    .valid(sel_valid)
  );
  assign sel_idx = PW'(oh_idx(8'(sel_oh)));
  always_comb begin
    loc_sel = '0;
    data_sel = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (sel_oh[k]) begin
        loc_sel = reqLocation[k*LCD_LOC_W +: LCD_LOC_W];
        data_sel = reqData[k*LCD_DATA_W +: LCD_DATA_W];
      end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    grant_d = '0;
    we_d = 1'b0;
    loc_d = loc_q;
    data_d = data_q;
    case (state_q)
      ST_IDLE:
        if (sel_valid) begin
          state_d = ST_ISSUE;
          grant_d = sel_oh;
          we_d = 1'b1;
          loc_d = loc_sel;
          data_d = data_sel;
          ptr_d = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end
      ST_ISSUE: begin
        state_d = (WRITE_GAP == 0) ? ST_IDLE : ST_GAP;
        cnt_d = GAP_LOAD;
      end
      ST_GAP: begin
        state_d = (cnt_q == '0) ? ST_IDLE : ST_GAP;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      grant_q <= '0;
      we_q <= 1'b0;
      loc_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      we_q <= we_d;
      loc_q <= loc_d;
      data_q <= data_d;
    end
  end
  assign grant = grant_q;
  assign lcdWriteEnable = we_q;
  assign lcdLocation = loc_q;
  assign lcdData = data_q;
  assign busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: table-driven selector vectors plus directed arbiter sequences.
module tb_lcd_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_a = '0, req_b = '0;
  logic [19:0] loc = '0;
  logic [31:0] dat = '0;
  logic [3:0] grant_a, grant_b;
  logic we_a, we_b, busy_a, busy_b;
  logic [4:0] loc_a, loc_b;
  logic [7:0] data_a, data_b;
  logic [3:0] u_req = '0, u_sel;
  logic [1:0] u_ptr = '0;
  logic u_valid;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcd_write_arbiter #(.NUM_REQ(4), .WRITE_GAP(4), .GAP_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .reqLocation(loc), .reqData(dat),
    .grant(grant_a), .lcdWriteEnable(we_a), .lcdLocation(loc_a), .lcdData(data_a), .busy(busy_a)
  );
  lcd_write_arbiter #(.NUM_REQ(4), .WRITE_GAP(0), .GAP_W(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .reqLocation(loc), .reqData(dat),
    .grant(grant_b), .lcdWriteEnable(we_b), .lcdLocation(loc_b), .lcdData(data_b), .busy(busy_b)
  );
  rr_priority_select #(.N(4)) u_rr (.req(u_req), .ptr(u_ptr), .sel(u_sel), .valid(u_valid));

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic [3:0] oh;
    logic       v;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_we(input int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!we_a && n < lim);
    checks++;
    if (!we_a) begin
      failures++;
      $display("FAIL strobe_timeout got=0 exp=1 after %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_g;
    tbl[0] = '{4'b0000, 2'd0, 4'b0000, 1'b0};
    tbl[1] = '{4'b0001, 2'd0, 4'b0001, 1'b1};
    tbl[2] = '{4'b0101, 2'd1, 4'b0100, 1'b1};
    tbl[3] = '{4'b0101, 2'd3, 4'b0001, 1'b1};
    tbl[4] = '{4'b1111, 2'd2, 4'b0100, 1'b1};
    tbl[5] = '{4'b1000, 2'd0, 4'b1000, 1'b1};
    tbl[6] = '{4'b0110, 2'd3, 4'b0010, 1'b1};
    tbl[7] = '{4'b1111, 2'd3, 4'b1000, 1'b1};
    tbl[8] = '{4'b0011, 2'd2, 4'b0001, 1'b1};
    tbl[9] = '{4'b1010, 2'd2, 4'b1000, 1'b1};
    for (int i = 0; i < 10; i++) begin
      u_req = tbl[i].req;
      u_ptr = tbl[i].ptr;
      #1;
      chk($sformatf("rr_sel[%0d]", i), 32'(u_sel), 32'(tbl[i].oh));
      chk($sformatf("rr_valid[%0d]", i), 32'(u_valid), 32'(tbl[i].v));
    end

    do_reset();
    chk("rst_grant", 32'(grant_a), 0);
    chk("rst_we", 32'(we_a), 0);
    chk("rst_loc", 32'(loc_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_busy", 32'(busy_a), 0);

    // Single request: strobe one cycle later, busy for WRITE_GAP+1 cycles.
    loc[4:0] = 5'd5;
    dat[7:0] = 8'h41;
    req_a = 4'b0001;
    tick();
    chk("single_we", 32'(we_a), 1);
    chk("single_grant", 32'(grant_a), 32'h1);
    chk("single_loc", 32'(loc_a), 5);
    chk("single_data", 32'(data_a), 32'h41);
    chk("single_busy0", 32'(busy_a), 1);
    req_a = '0;
    for (int c = 1; c < 5; c++) begin
      tick();
      chk($sformatf("single_busy%0d", c), 32'(busy_a), 1);
      chk($sformatf("single_we_low%0d", c), 32'({we_a, grant_a}), 0);
    end
    tick();
    chk("single_idle", 32'(busy_a), 0);
    chk("single_loc_hold", 32'({loc_a, data_a}), 32'({5'd5, 8'h41}));

    // Simultaneous requests 0 and 2 from reset.
    loc[4:0] = 5'd1;
    dat[7:0] = 8'h30;
    loc[14:10] = 5'd2;
    dat[23:16] = 8'h32;
    req_a = 4'b0101;
    do_reset();
    chk("sim_lat_none", 32'(we_a), 0);
    wait_we(10, n);
    chk("sim_first_grant", 32'(grant_a), 32'h1);
    chk("sim_first_loc", 32'(loc_a), 1);
    req_a = 4'b0100;
    wait_we(20, n);
    chk("sim_spacing", 32'(n), 6);
    chk("sim_second_grant", 32'(grant_a), 32'h4);
    chk("sim_second_data", 32'({loc_a, data_a}), 32'({5'd2, 8'h32}));
    req_a = '0;
    chk("sim_ptr", 32'(dut_a.ptr_q), 3);

    // Fairness: all requesters continuously pending.
    for (int k = 0; k < 4; k++) begin
      loc[k*5 +: 5] = 5'(k + 16);
      dat[k*8 +: 8] = 8'(8'h61 + k);
    end
    rst = 1'b1;
    req_a = 4'b1111;
    tick();
    rst = 1'b0;
    for (int w = 0; w < 12; w++) begin
      wait_we(20, n);
      exp_g = 1 << (w % 4);
      chk($sformatf("fair_grant%0d", w), 32'(grant_a), 32'(exp_g));
      chk($sformatf("fair_data%0d", w), 32'(data_a), 32'(8'h61 + (w % 4)));
      if (w > 0) chk($sformatf("fair_spacing%0d", w), 32'(n), 6);
    end
    req_a = '0;

    // WRITE_GAP=0: strobes every other cycle, alternating between two requesters.
    rst = 1'b1;
    req_b = 4'b0011;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("gap0_we%0d", c), 32'(we_b), 32'((c % 2) == 0));
      chk($sformatf("gap0_grant%0d", c), 32'(grant_b), (c % 2) ? 0 : ((c % 4) == 0 ? 32'h1 : 32'h2));
    end
    req_b = '0;

    // Reset during the second GAP cycle clears everything; pointer restarts at 0.
    do_reset();
    loc[4:0] = 5'd20;
    dat[7:0] = 8'h52;
    loc[9:5] = 5'd7;
    dat[15:8] = 8'h45;
    req_a = 4'b0001;
    tick();
    chk("mid_we", 32'(we_a), 1);
    chk("mid_write", 32'({loc_a, data_a}), 32'({5'd20, 8'h52}));
    req_a = 4'b0010;
    tick();
    tick();
    chk("mid_in_gap", 32'({busy_a, we_a}), 32'b10);
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", 32'({grant_a, we_a, loc_a, data_a, busy_a}), 0);
    rst = 1'b0;
    wait_we(10, n);
    chk("mid_after_lat", 32'(n), 1);
    chk("mid_after_grant", 32'(grant_a), 32'h2);
    chk("mid_after_data", 32'({loc_a, data_a}), 32'({5'd7, 8'h45}));
    req_a = '0;

    // Withdrawn request: req[3] pulses only during GAP.
    do_reset();
    loc[4:0] = 5'd3;
    req_a = 4'b0001;
    wait_we(10, n);
    req_a = '0;
    tick();
    req_a = 4'b1000;
    tick();
    req_a = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("withdraw%0d", c), 32'({grant_a, we_a}), 0);
    end
    chk("withdraw_idle", 32'(busy_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
Shares the single character-write port of LcdController (writeEnable, 5-bit location, 8-bit data) among several requesters, such as register-value display, name-label display and a status field. Each write is granted by round-robin over a per-requester req/grant handshake. Consecutive writeEnable pulses are spaced by a programmable gap so the LCD driver has time to complete each character. The block sits between the top-level display logic and LcdController, replacing direct drive of lcdWriteEnable/lcdLocation/writeCharacter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WRITE_GAP, 16, idle cycles forced after each write pulse before the next can issue (0 allowed)
GAP_W, 8, width of gap counter; WRITE_GAP must be < 2**GAP_W

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester write request; held high with stable location/data until granted
reqLocation  input  5*NUM_REQ  requester i location at bits [5i+4:5i]; 0-15 line 1, 16-31 line 2
reqData  input  8*NUM_REQ  requester i ASCII character at bits [8i+7:8i]
grant  output  NUM_REQ  one-hot, single-cycle acknowledge of the captured request
lcdWriteEnable  output  1  single-cycle write strobe to LcdController.writeEnable
lcdLocation  output  5  to LcdController.location
lcdData  output  8  to LcdController.data
busy  output  1  high in ISSUE and GAP states

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, grant=0, lcdWriteEnable=0, lcdLocation=0, lcdData=0, gap counter=0, rr pointer=0, busy=0. Reset mid-ISSUE or mid-GAP aborts immediately. No pending write survives.
- States: IDLE, ISSUE, GAP.
- IDLE: if any req bit is high, select the first requester at or after rr pointer, with circular wrap from NUM_REQ-1 to 0. At the edge, register its location/data into lcdLocation/lcdData, set grant to one-hot(sel), and go to ISSUE. The rr pointer becomes (sel+1) mod NUM_REQ. With no req, stay in IDLE and leave all outputs unchanged.
- ISSUE (exactly 1 cycle): lcdWriteEnable=1 and grant[sel]=1 in the same cycle. Next state is GAP with counter loaded to WRITE_GAP-1. If WRITE_GAP=0, go to IDLE.
- GAP: lcdWriteEnable=0, grant=0. Counter decrements each cycle; when it reaches 0, go to IDLE. req is ignored throughout GAP.
- Latency: req sampled high in IDLE gives the write strobe on the next cycle. Minimum spacing between strobes is WRITE_GAP+2 cycles.
- lcdLocation/lcdData hold their last written value outside ISSUE; they are never cleared except by reset.
- Handshake: a requester deasserts req, or presents its next character, on the edge after seeing grant. Because GAP/IDLE is at least one cycle, no double grant occurs.
- A req dropped before grant is legal; nothing is written for it.
- Simultaneous requests: only one is granted per ISSUE. The others stay pending and are served in rotating order, so no requester waits more than NUM_REQ writes.
- Location/data arithmetic: pure pass-through with no width change; out-of-range inputs cannot exist (5-bit).

Decomposition:
- Shared package lcd_pkg: LCD_LOC_W=5, LCD_DATA_W=8, LCD_LINE2_BASE=16, and the state encoding (IDLE/ISSUE/GAP, 2-bit).
- One natural sub-module: rr_priority_select. It is combinational; inputs are req vector and pointer, and outputs are a one-hot select plus a valid flag. It is unit-tested separately.

Test Plan:
- Single request: WRITE_GAP=4. req[0]=1 with loc=5, data=0x41 in IDLE. Expect lcdWriteEnable and grant[0] high exactly 1 cycle later, lcdLocation=5, lcdData=0x41, busy high for 5 cycles, then IDLE.
- Simultaneous requests: req[0] and req[2] high from reset with pointer 0. Expect req0 written first, then req2 exactly 6 cycles later (WRITE_GAP=4). Pointer ends at 3.
- Fairness: all 4 requesters continuously re-requesting for 12 writes. Expect grant order 0,1,2,3,0,1,2,3,0,1,2,3, and every strobe-to-strobe spacing equal to WRITE_GAP+2.
- Gap=0 corner: WRITE_GAP=0 with two requesters pending. Expect strobes every 2 cycles, with no two consecutive high cycles of lcdWriteEnable.
- Reset mid-operation: assert rst during the GAP cycle 2 after a write to loc=20, data=0x52. Expect all outputs 0 next cycle. After release with req[1] pending, expect grant[1] first, because the pointer was reset to 0 and req[0] is low.
- Withdrawn request: req[3] pulses for 1 cycle during GAP and is low by IDLE. Expect no grant and no strobe.
